// File: rtl/rvsteel_uart_fifo_pkg.sv
// Shared constants for the buffered UART front end: register offsets,
// STATUS bit positions and engine state encodings.
package rvsteel_uart_fifo_pkg;

    // Register offsets, identical on the CPU side and the UART side
    localparam logic [4:0] REG_TXDATA = 5'h00;
    localparam logic [4:0] REG_RXDATA = 5'h04;
    localparam logic [4:0] REG_STATUS = 5'h08;

    // STATUS register bit positions
    localparam int ST_TX_NOT_FULL  = 0;
    localparam int ST_RX_NOT_EMPTY = 1;
    localparam int ST_TX_IDLE      = 2;
    localparam int ST_TX_OVF       = 3;
    localparam int ST_RX_OVF       = 4;
    localparam int ST_TX_CNT_LSB   = 8;
    localparam int ST_RX_CNT_LSB   = 16;

    // Engine states
    typedef logic [2:0] fsm_state_t;

    localparam fsm_state_t S_IDLE          = 3'd0;
    localparam fsm_state_t S_RX_READ       = 3'd1;
    localparam fsm_state_t S_RX_WAIT       = 3'd2;
    localparam fsm_state_t S_TX_POLL       = 3'd3;
    localparam fsm_state_t S_TX_POLL_WAIT  = 3'd4;
    localparam fsm_state_t S_TX_WRITE      = 3'd5;
    localparam fsm_state_t S_TX_WRITE_WAIT = 3'd6;

endpackage

// File: rtl/rvsteel_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for the TX and RX buffers.
// Ports: clock, reset (sync, active-high), push_i/push_data_i, pop_i,
// head_o (current head), full_o, empty_o, count_o.
module rvsteel_sync_fifo
    import rvsteel_uart_fifo_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop on empty is ignored; a push into a full FIFO is only
    // accepted when a real pop frees the slot in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // DEPTH is a power of two, so pointers wrap naturally
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/rvsteel_uart_fifo.sv
// Buffered front end for rvsteel_uart: CPU writes fill a TX FIFO drained by
// an engine that polls the UART, and UART receive interrupts are serviced
// into an RX FIFO the CPU reads later.
// Ports: CPU side clock/reset, rw_address, read_*, write_*, irq; UART side
// uart_rw_address, uart_read_*, uart_write_*, uart_irq, uart_irq_response.
// Optional macro RVSTEEL_UART_FIFO_IRQ_EN drives irq from RX non-empty;
// without it irq is tied low.
module rvsteel_uart_fifo
    import rvsteel_uart_fifo_pkg::*;
#(
    parameter int TX_FIFO_DEPTH = 16,
    parameter int RX_FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  rw_address,
    output logic [31:0] read_data,
    input  logic        read_request,
    output logic        read_response,
    input  logic [7:0]  write_data,
    input  logic        write_request,
    output logic        write_response,
    output logic        irq,
    output logic [4:0]  uart_rw_address,
    input  logic [31:0] uart_read_data,
    output logic        uart_read_request,
    input  logic        uart_read_response,
    output logic [7:0]  uart_write_data,
    output logic        uart_write_request,
    input  logic        uart_write_response,
    input  logic        uart_irq,
    output logic        uart_irq_response
);

    localparam int TXCW = $clog2(TX_FIFO_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_FIFO_DEPTH) + 1;

    fsm_state_t state_q;
    fsm_state_t state_d;

    logic [31:0] read_data_q;
    logic [31:0] read_data_d;
    logic        read_response_q;
    logic        write_response_q;
    logic        tx_ovf_q;
    logic        tx_ovf_d;
    logic        rx_ovf_q;
    logic        rx_ovf_d;

    logic            cpu_wr_tx;
    logic            cpu_rd_rx;
    logic            cpu_rd_st;
    logic            tx_pop;
    logic [7:0]      tx_head;
    logic            tx_full;
    logic            tx_empty;
    logic [TXCW-1:0] tx_count;
    logic            rx_push;
    logic [7:0]      rx_head;
    logic            rx_full;
    logic            rx_empty;
    logic [RXCW-1:0] rx_count;
    logic            tx_drop;
    logic            rx_drop;
    logic [31:0]     status;
    logic            unused_bits;

    assign unused_bits = ^uart_read_data[31:8];

    assign cpu_wr_tx = write_request && (rw_address == REG_TXDATA);
    assign cpu_rd_rx = read_request && (rw_address == REG_RXDATA);
    assign cpu_rd_st = read_request && (rw_address == REG_STATUS);

    assign tx_pop  = (state_q == S_TX_WRITE);
    assign rx_push = (state_q == S_RX_WAIT) && uart_read_response;

    // A full FIFO is never empty, so any CPU RXDATA read (or engine TX
    // write) is a real pop that makes room for the incoming byte.
    assign tx_drop = cpu_wr_tx && tx_full && !tx_pop;
    assign rx_drop = rx_push && rx_full && !cpu_rd_rx;

    rvsteel_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_FIFO_DEPTH)
    ) u_tx_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (cpu_wr_tx),
        .push_data_i (write_data),
        .pop_i       (tx_pop),
        .head_o      (tx_head),
        .full_o      (tx_full),
        .empty_o     (tx_empty),
        .count_o     (tx_count)
    );

    rvsteel_sync_fifo #(
        .WIDTH (8),
        .DEPTH (RX_FIFO_DEPTH)
    ) u_rx_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (rx_push),
        .push_data_i (uart_read_data[7:0]),
        .pop_i       (cpu_rd_rx),
        .head_o      (rx_head),
        .full_o      (rx_full),
        .empty_o     (rx_empty),
        .count_o     (rx_count)
    );

    // Engine next state; receive service has priority over transmit
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (uart_irq) state_d = S_RX_READ;
                else if (!tx_empty) state_d = S_TX_POLL;
            end
            S_RX_READ: state_d = S_RX_WAIT;
            S_RX_WAIT: begin
                if (uart_read_response) state_d = S_IDLE;
            end
            S_TX_POLL: state_d = S_TX_POLL_WAIT;
            S_TX_POLL_WAIT: begin
                if (uart_read_response) begin
                    state_d = uart_read_data[0] ? S_TX_WRITE : S_IDLE;
                end
            end
            S_TX_WRITE: state_d = S_TX_WRITE_WAIT;
            S_TX_WRITE_WAIT: begin
                if (uart_write_response) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // UART-side outputs are pure decodes of the engine state
    always_comb begin
        uart_rw_address    = 5'h00;
        uart_read_request  = 1'b0;
        uart_write_request = 1'b0;
        uart_write_data    = 8'h00;
        uart_irq_response  = 1'b0;
        case (state_q)
            S_RX_READ: begin
                uart_rw_address   = REG_RXDATA;
                uart_read_request = 1'b1;
                uart_irq_response = 1'b1;
            end
            S_TX_POLL: begin
                uart_rw_address   = REG_STATUS;
                uart_read_request = 1'b1;
            end
            S_TX_WRITE: begin
                uart_rw_address    = REG_TXDATA;
                uart_write_data    = tx_head;
                uart_write_request = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        status                 = 32'h0;
        status[ST_TX_NOT_FULL]  = !tx_full;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_TX_IDLE]      = tx_empty && (state_q == S_IDLE);
        status[ST_TX_OVF]       = tx_ovf_q;
        status[ST_RX_OVF]       = rx_ovf_q;
        status[ST_TX_CNT_LSB +: 8] = 8'(tx_count);
        status[ST_RX_CNT_LSB +: 8] = 8'(rx_count);
    end

    always_comb begin
        read_data_d = 32'h0;
        if (cpu_rd_rx) begin
            read_data_d = rx_empty ? 32'h0 : {24'h0, rx_head};
        end else if (cpu_rd_st) begin
            read_data_d = status;
        end
    end

    // Sticky flags: a STATUS read clears them for the next cycle, but a
    // new overflow in the read cycle survives so no event is lost.
    always_comb begin
        tx_ovf_d = tx_ovf_q;
        rx_ovf_d = rx_ovf_q;
        if (cpu_rd_st) begin
            tx_ovf_d = 1'b0;
            rx_ovf_d = 1'b0;
        end
        if (tx_drop) tx_ovf_d = 1'b1;
        if (rx_drop) rx_ovf_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= S_IDLE;
            read_data_q      <= 32'h0;
            read_response_q  <= 1'b0;
            write_response_q <= 1'b0;
            tx_ovf_q         <= 1'b0;
            rx_ovf_q         <= 1'b0;
        end else begin
            state_q          <= state_d;
            read_data_q      <= read_data_d;
            read_response_q  <= read_request;
            write_response_q <= write_request;
            tx_ovf_q         <= tx_ovf_d;
            rx_ovf_q         <= rx_ovf_d;
        end
    end

    assign read_data      = read_data_q;
    assign read_response  = read_response_q;
    assign write_response = write_response_q;

`ifdef RVSTEEL_UART_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock) begin
        if (reset) irq_q <= 1'b0;
        else irq_q <= (rx_count != '0);
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_rvsteel_uart_fifo.sv
// Self-checking bench for rvsteel_uart_fifo with a behavioural UART model
// and queue-based reference model.
module tb_rvsteel_uart_fifo;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rw_address = '0;
    logic [31:0] read_data;
    logic        read_request = 1'b0;
    logic        read_response;
    logic [7:0]  write_data = '0;
    logic        write_request = 1'b0;
    logic        write_response;
    logic        irq;
    logic [4:0]  uart_rw_address;
    logic [31:0] uart_read_data = '0;
    logic        uart_read_request;
    logic        uart_read_response = 1'b0;
    logic [7:0]  uart_write_data;
    logic        uart_write_request;
    logic        uart_write_response = 1'b0;
    logic        uart_irq = 1'b0;
    logic        uart_irq_response;

    always #5 clock = ~clock;

    rvsteel_uart_fifo #(
        .TX_FIFO_DEPTH (16),
        .RX_FIFO_DEPTH (16)
    ) dut (
        .clock               (clock),
        .reset               (reset),
        .rw_address          (rw_address),
        .read_data           (read_data),
        .read_request        (read_request),
        .read_response       (read_response),
        .write_data          (write_data),
        .write_request       (write_request),
        .write_response      (write_response),
        .irq                 (irq),
        .uart_rw_address     (uart_rw_address),
        .uart_read_data      (uart_read_data),
        .uart_read_request   (uart_read_request),
        .uart_read_response  (uart_read_response),
        .uart_write_data     (uart_write_data),
        .uart_write_request  (uart_write_request),
        .uart_write_response (uart_write_response),
        .uart_irq            (uart_irq),
        .uart_irq_response   (uart_irq_response)
    );

    int checks = 0;
    int errors = 0;

    // UART model state
    logic       hold_busy = 1'b0;
    int         byte_time = 20;
    int         busy_cnt = 0;
    logic [7:0] sent[$];
    int         write_viol = 0;
    int         prio_viol = 0;
    int         irq_pulses = 0;
    int         rx_req_cnt = 0;
    int         rx_seen_cnt = 0;
    logic [7:0] rx_byte_m = '0;
    logic       irq_prev = 1'b0;

    // Reference model state
    logic [7:0] rxm[$];
    logic [7:0] txm[$];
    logic       rx_ovf_m = 1'b0;
    int         tx_base = 0;

    always @(posedge clock) begin
        uart_read_response  <= uart_read_request;
        uart_write_response <= uart_write_request;
        irq_prev            <= uart_irq;
        if (uart_read_request) begin
            if (uart_rw_address == 5'h08) begin
                uart_read_data <= {31'h0, (busy_cnt == 0) && !hold_busy};
                if (irq_prev) prio_viol <= prio_viol + 1;
            end else if (uart_rw_address == 5'h04) begin
                uart_read_data <= {24'h0, rx_byte_m};
            end else begin
                uart_read_data <= 32'h0;
            end
        end
        if (uart_write_request) begin
            sent.push_back(uart_write_data);
            if (busy_cnt != 0 || hold_busy) write_viol <= write_viol + 1;
            busy_cnt <= byte_time;
        end else if (busy_cnt > 0) begin
            busy_cnt <= busy_cnt - 1;
        end
        if (uart_irq_response) begin
            uart_irq   <= 1'b0;
            irq_pulses <= irq_pulses + 1;
        end else if (rx_seen_cnt != rx_req_cnt) begin
            uart_irq    <= 1'b1;
            rx_seen_cnt <= rx_seen_cnt + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clock);
    endtask

    task automatic cpu_write(input logic [7:0] b, input logic [4:0] a = 5'h00);
        rw_address    = a;
        write_data    = b;
        write_request = 1'b1;
        @(negedge clock);
        write_request = 1'b0;
        rw_address    = '0;
        write_data    = '0;
        check("write_response", {31'h0, write_response}, 32'h1);
    endtask

    task automatic cpu_read(input logic [4:0] a, output logic [31:0] d);
        rw_address   = a;
        read_request = 1'b1;
        @(negedge clock);
        read_request = 1'b0;
        rw_address   = '0;
        d = read_data;
        check("read_response", {31'h0, read_response}, 32'h1);
    endtask

    task automatic read_rx_check(input string name);
        logic [31:0] d;
        logic [31:0] e;
        cpu_read(5'h04, d);
        e = 32'h0;
        if (rxm.size() != 0) e = {24'h0, rxm.pop_front()};
        check(name, d, e);
    endtask

    task automatic status_check(input string name, input logic [31:0] mask,
                                input logic [31:0] txpart);
        logic [31:0] d;
        logic [31:0] e;
        cpu_read(5'h08, d);
        e = txpart;
        e[1] = (rxm.size() != 0);
        e[4] = rx_ovf_m;
        e[23:16] = 8'(rxm.size());
        check(name, d & mask, e & mask);
        rx_ovf_m = 1'b0;
    endtask

    task automatic irq_check(input string name);
        logic e;
        tick(2);
`ifdef RVSTEEL_UART_FIFO_IRQ_EN
        e = (rxm.size() != 0);
`else
        e = 1'b0;
`endif
        check(name, {31'h0, irq}, {31'h0, e});
    endtask

    task automatic deliver(input logic [7:0] b);
        int p;
        int t;
        p = irq_pulses;
        rx_byte_m = b;
        rx_req_cnt++;
        t = 0;
        while (irq_pulses == p && t < 300) begin
            tick();
            t++;
        end
        tick(3);
        check("irq_response_once", irq_pulses - p, 1);
        if (rxm.size() < 16) rxm.push_back(b);
        else rx_ovf_m = 1'b1;
    endtask

    task automatic wait_tx(input string name, input int limit);
        int t;
        t = 0;
        while ((sent.size() - tx_base) < txm.size() && t < limit) begin
            tick();
            t++;
        end
        check({name, "_count"}, sent.size() - tx_base, txm.size());
        for (int i = 0; i < txm.size(); i++) begin
            if (tx_base + i < sent.size())
                check({name, "_byte"}, {24'h0, sent[tx_base+i]}, {24'h0, txm[i]});
            else
                check({name, "_byte"}, 32'hDEAD, {24'h0, txm[i]});
        end
        tx_base = sent.size();
        txm.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        rxm.delete();
        txm.delete();
        rx_ovf_m = 1'b0;
        tx_base = sent.size();
    endtask

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [7:0]  wdata;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [31:0] d;
        int t;
        int nwr;

        vecs[0] = '{1'b0, 5'h08, 8'h00, 32'h0000_0005, "st_reset"};
        vecs[1] = '{1'b0, 5'h04, 8'h00, 32'h0000_0000, "rx_empty"};
        vecs[2] = '{1'b0, 5'h0C, 8'h00, 32'h0000_0000, "bad_addr_0c"};
        vecs[3] = '{1'b0, 5'h1F, 8'h00, 32'h0000_0000, "bad_addr_1f"};
        vecs[4] = '{1'b1, 5'h00, 8'h11, 32'h0, "wr_11"};
        vecs[5] = '{1'b0, 5'h08, 8'h00, 32'h0000_0101, "st_one"};
        vecs[6] = '{1'b1, 5'h00, 8'h22, 32'h0, "wr_22"};
        vecs[7] = '{1'b0, 5'h08, 8'h00, 32'h0000_0201, "st_two"};
        vecs[8] = '{1'b1, 5'h04, 8'h33, 32'h0, "wr_bad"};
        vecs[9] = '{1'b0, 5'h08, 8'h00, 32'h0000_0201, "st_still_two"};

        tick(3);
        reset = 1'b0;
        check("rst_read_data", read_data, 32'h0);
        check("rst_outputs",
              {13'h0, uart_rw_address, uart_write_data, uart_read_request,
               uart_write_request, uart_irq_response, read_response,
               write_response, irq}, 32'h0);

        // Register map basics with the UART held busy
        hold_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].wr) begin
                cpu_write(vecs[i].wdata, vecs[i].addr);
            end else begin
                cpu_read(vecs[i].addr, d);
                check(vecs[i].name, d, vecs[i].exp);
            end
        end

        // TX overflow: 17 writes into a 16-deep FIFO
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cpu_write(8'(8'h60 + i));
            if (i < 16) txm.push_back(8'(8'h60 + i));
        end
        status_check("st_tx_ovf", 32'hFFFF_FFFF, 32'h0000_1008);
        status_check("st_tx_ovf_clr", 32'hFFFF_FFFF, 32'h0000_1000);
        hold_busy = 1'b0;
        wait_tx("tx_ovf_drain", 3000);

        // Exact timing of the first poll and write, then slow UART
        byte_time = 1000;
        tick(50);
        cpu_write(8'h41);
        txm.push_back(8'h41);
        check("poll_not_yet", {31'h0, uart_read_request}, 32'h0);
        cpu_write(8'h42);
        txm.push_back(8'h42);
        check("poll_cycle2", {26'h0, uart_read_request, uart_rw_address},
              {26'h0, 1'b1, 5'h08});
        tick(2);
        check("write_cycle4", {23'h0, uart_write_request, uart_write_data},
              {23'h0, 1'b1, 8'h41});
        wait_tx("tx_slow", 5000);
        check("write_while_busy", write_viol, 0);

        // Single RX byte
        byte_time = 20;
        tick(50);
        deliver(8'h5A);
        irq_check("irq_rx_pending");
        read_rx_check("rx_5a");
        irq_check("irq_rx_drained");

        // RX has priority over a pending TX byte
        rx_byte_m = 8'h77;
        rx_req_cnt++;
        cpu_write(8'h99);
        txm.push_back(8'h99);
        check("prio_irq_seen", {31'h0, uart_irq}, 32'h1);
        tick();
        check("prio_rx_first",
              {25'h0, uart_read_request, uart_rw_address, uart_irq_response},
              {25'h0, 1'b1, 5'h04, 1'b1});
        tick(3);
        check("prio_tx_poll", {26'h0, uart_read_request, uart_rw_address},
              {26'h0, 1'b1, 5'h08});
        rxm.push_back(8'h77);
        wait_tx("tx_prio", 2000);
        read_rx_check("rx_77");

        // RX overflow and in-order readback across pointer wrap
        for (int i = 0; i < 17; i++) deliver(8'($urandom));
        status_check("st_rx_ovf", 32'hFFFF_FFFF, 32'h0000_0005);
        irq_check("irq_rx_full");
        for (int i = 0; i < 16; i++) read_rx_check("rx_fill_read");
        irq_check("irq_rx_empty");
        status_check("st_rx_clean", 32'hFFFF_FFFF, 32'h0000_0005);

        // Randomized mixed traffic against the reference model
        byte_time = 5;
        nwr = 0;
        for (int i = 0; i < 200; i++) begin
            case ($urandom_range(0, 4))
                0: begin
                    if (nwr < 12) begin
                        d[7:0] = 8'($urandom);
                        cpu_write(d[7:0]);
                        txm.push_back(d[7:0]);
                        nwr++;
                    end
                end
                1: deliver(8'($urandom));
                2: read_rx_check("rnd_rx");
                3: status_check("rnd_status", 32'h00FF_001A, 32'h0);
                default: irq_check("rnd_irq");
            endcase
        end
        wait_tx("tx_rnd", 3000);
        check("rnd_write_viol", write_viol, 0);
        check("rx_priority", prio_viol, 0);

        // Reset while waiting for a poll response
        tick(20);
        hold_busy = 1'b1;
        cpu_write(8'h55);
        t = 0;
        while (!(uart_read_request && uart_rw_address == 5'h08) && t < 100) begin
            tick();
            t++;
        end
        check("poll_seen", {31'h0, uart_read_request}, 32'h1);
        tick();
        reset = 1'b1;
        tick();
        check("rst_mid_read_data", read_data, 32'h0);
        check("rst_mid_outputs",
              {13'h0, uart_rw_address, uart_write_data, uart_read_request,
               uart_write_request, uart_irq_response, read_response,
               write_response, irq}, 32'h0);
        reset = 1'b0;
        rxm.delete();
        txm.delete();
        rx_ovf_m = 1'b0;
        tick();
        check("rst_mid_idle", {31'h0, uart_read_request}, 32'h0);
        status_check("rst_mid_status", 32'hFFFF_FFFF, 32'h0000_0005);
        hold_busy = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rvsteel_uart_fifo.md
# rvsteel_uart_fifo

Buffered front end for `rvsteel_uart`, placed between the CPU bus and the UART's IO port. CPU-side writes go into a TX FIFO, which an internal engine drains into the UART only when the UART reports idle. The engine also services the UART receive interrupt, reads the byte and pushes it into an RX FIFO for the CPU to read at leisure. This gives software multi-byte buffering without polling the UART per bit-time.

## Interface
- `TX_FIFO_DEPTH`, 16: TX entries; power of two, at least 2.
- `RX_FIFO_DEPTH`, 16: RX entries; power of two, at least 2.
- `clock  in  1`: single clock.
- `reset  in  1`: synchronous, active-high.
- `rw_address  in  5`: CPU-side register address.
- `read_data  out  32`: CPU read data, registered.
- `read_request  in  1` / `read_response  out  1`: CPU read handshake.
- `write_data  in  8`: CPU write byte.
- `write_request  in  1` / `write_response  out  1`: CPU write handshake.
- `irq  out  1`: high while the RX FIFO is non-empty (see Configuration).
- `uart_rw_address  out  5`: address driven to the UART.
- `uart_read_data  in  32`: UART read data.
- `uart_read_request  out  1` / `uart_read_response  in  1`: UART read handshake.
- `uart_write_data  out  8`: byte driven to the UART.
- `uart_write_request  out  1` / `uart_write_response  in  1`: UART write handshake.
- `uart_irq  in  1`: UART receive interrupt.
- `uart_irq_response  out  1`: acknowledge for `uart_irq`.

## Operation
- **CPU register map**
  - 0x00 TXDATA (write): pushes `write_data`. If the TX FIFO is full the byte is dropped and sticky `tx_ovf` is set.
  - 0x04 RXDATA (read): returns `{24'b0, head}` and pops the RX FIFO. If empty, returns 0 and does not pop.
  - 0x08 STATUS (read):
    - bit0: TX FIFO not full.
    - bit1: RX FIFO not empty.
    - bit2: TX FIFO empty and engine in IDLE.
    - bit3: `tx_ovf`.
    - bit4: `rx_ovf`.
    - [15:8]: TX count.
    - [23:16]: RX count.
    - Reading STATUS clears both sticky bits on the following cycle. A set event in that same cycle wins over the clear.
- Any other address or non-request cycle gives `read_data` = 0.
- `read_response`/`write_response` = the respective request delayed one cycle.
- **Engine FSM (UART master)**
  - IDLE: `uart_irq` → RX_READ; else TX FIFO non-empty → TX_POLL; else stay. RX has priority.
  - RX_READ, one cycle: address 0x04, `uart_read_request`=1, `uart_irq_response`=1 → RX_WAIT.
  - RX_WAIT: on `uart_read_response`, push `uart_read_data[7:0]` into the RX FIFO. If the FIFO is full, drop the byte and set `rx_ovf`. → IDLE.
  - TX_POLL, one cycle: address 0x08, `uart_read_request`=1 → TX_POLL_WAIT.
  - TX_POLL_WAIT: on response, bit0=1 → TX_WRITE; bit0=0 → IDLE (re-arbitrate).
  - TX_WRITE, one cycle: address 0x00, data = TX head, `uart_write_request`=1, pop TX → TX_WRITE_WAIT.
  - TX_WRITE_WAIT: on `uart_write_response` → IDLE.
- UART-side outputs are decoded from state. Address and data are 0 outside their states.
- **FIFO rules**
  - Push is accepted iff not full, or a pop occurs in the same cycle.
  - Pop on empty is ignored. Simultaneous push and pop on empty performs the push only.
  - Pointers wrap modulo depth. Count width is clog2(DEPTH)+1.

## Timing
- **Reset values:** FSM=IDLE, FIFOs empty, sticky bits 0, every output 0.
- Reset mid-transaction aborts it. A UART byte in flight completes on the line; the UART's own reset is separate.
- A CPU TXDATA write at cycle 0 gives TX count 1 at cycle 1.
- With the UART idle and no RX pending: TX_POLL at cycle 2, TX_WRITE at cycle 4.
- Back-to-back bytes: the next poll starts no earlier than 2 cycles after TX_WRITE. The UART shows busy by then.
- When `uart_irq` rises in IDLE, `uart_irq_response` is asserted 1 cycle later. The RX byte is visible in the RX FIFO 2 cycles after RX_READ.
- A CPU RXDATA pop in the same cycle as an engine push: both occur and the count is unchanged.

## Configuration
- `RVSTEEL_UART_FIFO_IRQ_EN`
  - Defined: `irq` = RX FIFO non-empty (level, registered from count).
  - Undefined: `irq` is tied to 0 and software polls STATUS bit1. The port still exists.

## Structure
- Shared package holds:
  - Register offsets `REG_TXDATA`/`REG_RXDATA`/`REG_STATUS` (0x00/0x04/0x08), matching the UART map.
  - STATUS bit positions.
  - The FSM state enum.
- One sub-module, `rvsteel_sync_fifo`:
  - Parameters `WIDTH` and `DEPTH`.
  - First-word-fall-through output, plus full/empty/count.
  - Instantiated twice, for TX and RX.

## Test plan
- Write 0x41, 0x42 to TXDATA with a UART model at 100 cycles/baud → UART receives 0x41 then 0x42. Neither write is issued while UART STATUS bit0 = 0.
- Write 17 bytes with `TX_FIFO_DEPTH`=16 and the UART held busy → 17th dropped, STATUS bit3=1, TX count=16. The STATUS read clears bit3.
- Model raises `uart_irq` with rx byte 0x5A → `uart_irq_response` pulses once. RXDATA read returns 0x0000005A; `irq` falls (IRQ_EN defined).
- `uart_irq` while the TX FIFO is non-empty in IDLE → RX serviced first, then TX poll.
- Fill the RX FIFO with 16 bytes, deliver a 17th → dropped, bit4=1. The 16 stored bytes read back in order, wrapping pointers.
- Assert `reset` during TX_POLL_WAIT → next cycle all outputs 0, FIFOs empty, FSM IDLE.
